// File: rtl/mul_32.sv
// mul_32: iterative 32x32 -> 64-bit shift-add multiplier with per-operand signedness.
// Accept on start when idle, 32 compute cycles, one-cycle done pulse; lo/hi hold the last product.
`default_nettype none

module mul_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] sum, prod;

  // Negating -2^(WIDTH-1) wraps back to the same bit pattern, which is the
  // correct unsigned magnitude.
  always_comb begin
    a_neg = a_signed & a[WIDTH-1];
    b_neg = b_signed & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
    sum   = acc + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});
    prod  = neg ? (~sum + 1'b1) : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      lo     <= '0;
      hi     <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy   <= 1'b1;
          cnt    <= '0;
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, a_mag};
          mplier <= b_mag;
          neg    <= a_neg ^ b_neg;
        end
      end else begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          lo   <= prod[WIDTH-1:0];
          hi   <= prod[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_32.sv
// tb_mul_32: directed vectors with hand-computed products, checked by a queue-based
// scoreboard that is popped whenever the multiplier pulses done.
`default_nettype none

module tb_mul_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        a_signed = 1'b0;
  logic        b_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] lo, hi;

  mul_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_signed(a_signed), .b_signed(b_signed),
    .a(a), .b(b), .busy(busy), .done(done), .lo(lo), .hi(hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] p;
    int          c;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          busy_run = 0;
  logic [63:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, well away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
        last_res = '0;
      end else if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("product", {hi, lo}, e.p);
          check("latency", 64'(cyc - e.c), 64'd32);
          check("busy_len", 64'(busy_run), 64'd32);
          check("busy_at_done", {63'd0, busy}, 64'd0);
        end
        last_res = {hi, lo};
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if ({hi, lo} !== last_res) check("hold", {hi, lo}, last_res);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(q.size()), 64'd0);
  endtask

  // Drive one request at a falling edge; it is accepted on the next rising edge.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic sa,
                       input logic sb, input logic [63:0] p);
    exp_t e;
    @(negedge clk);
    wait_idle();
    a = va; b = vb; a_signed = sa; b_signed = sb; start = 1'b1;
    e.p = p;
    e.c = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   prev_acc;
    int   n_acc;

    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_prod", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'd2, 32'd3, 1'b0, 1'b0, 64'd6);
    issue(32'd5, 32'd6, 1'b0, 1'b0, 64'd30);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);
    issue(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
    issue(32'h80000000, 32'h00000001, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    issue(32'h00000003, 32'hFFFFFFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(32'h00000000, 32'h12345678, 1'b1, 1'b1, 64'd0);

    // Operands change and start re-asserts mid-operation; the result must not move.
    issue(32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h0000_0001_0000_0000);
    repeat (5) @(negedge clk);
    a = 32'd7; b = 32'd9; a_signed = 1'b1; b_signed = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_drain();

    // start held high: a new accept whenever busy is low at the falling edge.
    @(negedge clk);
    wait_idle();
    a = 32'h12345678; b = 32'h10; a_signed = 1'b0; b_signed = 1'b0; start = 1'b1;
    prev_acc = -1;
    n_acc = 0;
    while (n_acc < 3) begin
      if (!busy) begin
        e.p = 64'h0000_0001_2345_6780;
        e.c = cyc + 1;
        q.push_back(e);
        if (prev_acc >= 0) check("period", 64'(e.c - prev_acc), 64'd33);
        prev_acc = e.c;
        n_acc++;
      end
      @(negedge clk);
    end
    while (busy) @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset at cycle 10 of a running multiply.
    issue(32'd100, 32'd200, 1'b0, 1'b0, 64'd20000);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_prod", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", 64'(q.size()), 64'd0);

    issue(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 64'h0000_0000_FFFE_0001);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
